// File: rtl/sel_accum_pkg.sv
// Shared lane state encoding and the wrap/saturate adder used by every lane.
package sel_accum_pkg;

   localparam int SA_MAXW = 32;

   typedef logic [SA_MAXW-1:0] sa_word_t;

   typedef enum logic {RUN, HOLD} lane_state_t;

   // Returns {carry, sum}. Carry flags any result above 2**w-1.
   // mode=0 keeps the low w bits; mode=1 clamps the result to 2**w-1.
   function automatic logic [SA_MAXW:0] sat_add(input sa_word_t a, input sa_word_t b,
                                                input logic mode, input int unsigned w);
      logic [SA_MAXW:0] s;
      logic [SA_MAXW:0] lim;
      lim = ({{SA_MAXW{1'b0}}, 1'b1} << w) - 1'b1;
      s   = {1'b0, a} + {1'b0, b};
      if (s > lim)
         sat_add = {1'b1, mode ? lim[SA_MAXW-1:0] : (s[SA_MAXW-1:0] & lim[SA_MAXW-1:0])};
      else
         sat_add = {1'b0, s[SA_MAXW-1:0]};
   endfunction

endpackage

// File: rtl/sel_accum_lane.sv
// One lane: x/y counters stepped by the selector, registered c = x'+y',
// a RUN/HOLD stop machine and a sticky overflow flag.
module sel_accum_lane
   import sel_accum_pkg::*;
#(
   parameter int WIDTH    = 11,
   parameter int STEP_A   = 1,
   parameter int STEP_B   = 2,
   parameter int BOUND    = 0,
   parameter int SAT_MODE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic             restart,
   output logic [WIDTH-1:0] c,
   output logic             done,
   output logic             overflow
);

   localparam logic MODE = (SAT_MODE != 0);

   logic [WIDTH-1:0]   x, y, xn, yn, cn;
   logic [SA_MAXW:0]   ax, ay, ac;
   logic               xc, yc, cc, hit;
   lane_state_t        state, state_d;

   always_comb begin
      ax = sat_add(sa_word_t'(x), sa_word_t'(STEP_A), MODE, WIDTH);
      ay = sat_add(sa_word_t'(y), sa_word_t'(STEP_B), MODE, WIDTH);
      xn = sel ? ax[WIDTH-1:0] : x;
      yn = sel ? y : ay[WIDTH-1:0];
      // upper sum bits are always zero after wrap/clamp; folding them in keeps every bit live
      xc = sel  & (ax[SA_MAXW] | (|ax[SA_MAXW-1:WIDTH]));
      yc = ~sel & (ay[SA_MAXW] | (|ay[SA_MAXW-1:WIDTH]));
      ac = sat_add(sa_word_t'(xn), sa_word_t'(yn), MODE, WIDTH);
      cn = ac[WIDTH-1:0];
      cc = ac[SA_MAXW] | (|ac[SA_MAXW-1:WIDTH]);
      hit = (BOUND != 0) && (sa_word_t'(cn) >= sa_word_t'(BOUND));
   end

   always_comb begin
      state_d = state;
      if (restart)
         state_d = RUN;
      else if (state == RUN && hit)
         state_d = HOLD;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         x        <= '0;
         y        <= '0;
         c        <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_d;
         if (restart) begin
            x        <= '0;
            y        <= '0;
            c        <= '0;
            overflow <= 1'b0;
         end else if (state == RUN) begin
            x        <= xn;
            y        <= yn;
            c        <= cn;
            overflow <= overflow | xc | yc | cc;
         end
      end
   end

   assign done = (state == HOLD);

endmodule

// File: rtl/sel_accum_array.sv
// CHANNELS independent selector-driven accumulator lanes with packed outputs.
module sel_accum_array
   import sel_accum_pkg::*;
#(
   parameter int WIDTH    = 11,
   parameter int CHANNELS = 4,
   parameter int STEP_A   = 1,
   parameter int STEP_B   = 2,
   parameter int BOUND    = 0,
   parameter int SAT_MODE = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       selector,
   input  logic [CHANNELS-1:0]       restart,
   output logic [CHANNELS*WIDTH-1:0] c,
   output logic [CHANNELS-1:0]       done,
   output logic [CHANNELS-1:0]       overflow
);

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      sel_accum_lane #(
         .WIDTH    (WIDTH),
         .STEP_A   (STEP_A),
         .STEP_B   (STEP_B),
         .BOUND    (BOUND),
         .SAT_MODE (SAT_MODE)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .sel      (selector[k]),
         .restart  (restart[k]),
         .c        (c[k*WIDTH +: WIDTH]),
         .done     (done[k]),
         .overflow (overflow[k])
      );
   end

endmodule

// File: tb/tb_sel_accum_array.sv
// Directed bench: wrap, saturate and bounded variants driven by one shared stimulus.
module tb_sel_accum_array;

   localparam int W = 11;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   selector, restart;
   logic [N*W-1:0] c_w, c_s, c_b;
   logic [N-1:0]   done_w, done_s, done_b, ov_w, ov_s, ov_b;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sel_accum_array #(.WIDTH(W), .CHANNELS(N)) dut_w (
      .clk(clk), .rst(rst), .selector(selector), .restart(restart),
      .c(c_w), .done(done_w), .overflow(ov_w));

   sel_accum_array #(.WIDTH(W), .CHANNELS(N), .SAT_MODE(1)) dut_s (
      .clk(clk), .rst(rst), .selector(selector), .restart(restart),
      .c(c_s), .done(done_s), .overflow(ov_s));

   sel_accum_array #(.WIDTH(W), .CHANNELS(N), .BOUND(100)) dut_b (
      .clk(clk), .rst(rst), .selector(selector), .restart(restart),
      .c(c_b), .done(done_b), .overflow(ov_b));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [N*W-1:0] pk(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                         input logic [W-1:0] l2, input logic [W-1:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   initial begin
      rst = 1'b1; selector = '0; restart = '0;
      tick(2);
      chk("rst_c_w",    64'(c_w),    64'(0));
      chk("rst_c_s",    64'(c_s),    64'(0));
      chk("rst_done_b", 64'(done_b), 64'(0));
      chk("rst_ov_w",   64'(ov_w),   64'(0));
      rst = 1'b0;

      selector = 4'b0001;
      tick(10);
      chk("mix_c_w",    64'(c_w),    64'(pk(10, 20, 20, 20)));
      chk("mix_ov_w",   64'(ov_w),   64'(0));
      chk("mix_c_b",    64'(c_b),    64'(pk(10, 20, 20, 20)));
      chk("mix_done_b", 64'(done_b), 64'(0));

      restart = 4'b0101;
      tick(1);
      restart = '0;
      chk("part_restart_c_w", 64'(c_w), 64'(pk(0, 22, 0, 22)));

      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      selector = '0;
      tick(50);
      chk("y_bound_c_b",    64'(c_b),    64'(pk(100, 100, 100, 100)));
      chk("y_bound_done_b", 64'(done_b), 64'(4'hF));
      tick(973);
      chk("pre_wrap_c_w",  64'(c_w),  64'(pk(2046, 2046, 2046, 2046)));
      chk("pre_wrap_ov_w", 64'(ov_w), 64'(0));
      chk("pre_sat_ov_s",  64'(ov_s), 64'(0));
      tick(1);
      chk("wrap_c_w",  64'(c_w),  64'(0));
      chk("wrap_ov_w", 64'(ov_w), 64'(4'hF));
      chk("sat_c_s",   64'(c_s),  64'(pk(2047, 2047, 2047, 2047)));
      chk("sat_ov_s",  64'(ov_s), 64'(4'hF));
      chk("held_c_b",  64'(c_b),  64'(pk(100, 100, 100, 100)));
      tick(5);
      chk("sat_hold_c_s", 64'(c_s), 64'(pk(2047, 2047, 2047, 2047)));

      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst_mid_done_b", 64'(done_b), 64'(0));
      chk("rst_mid_ov_s",   64'(ov_s),   64'(0));
      selector = 4'hF;
      tick(99);
      chk("x99_c_b",    64'(c_b),    64'(pk(99, 99, 99, 99)));
      chk("x99_done_b", 64'(done_b), 64'(0));
      tick(1);
      chk("x100_c_b",    64'(c_b),    64'(pk(100, 100, 100, 100)));
      chk("x100_done_b", 64'(done_b), 64'(4'hF));
      for (int i = 0; i < 20; i++) begin
         selector = 4'($urandom_range(0, 15));
         tick(1);
      end
      chk("frozen_c_b",    64'(c_b),    64'(pk(100, 100, 100, 100)));
      chk("frozen_done_b", 64'(done_b), 64'(4'hF));

      selector = 4'b0001;
      restart  = 4'b0001;
      tick(1);
      chk("restart_c_b",    64'(c_b),    64'(pk(0, 100, 100, 100)));
      chk("restart_done_b", 64'(done_b), 64'(4'b1110));
      restart = '0;
      tick(1);
      chk("rerun_c_b", 64'(c_b),  64'(pk(1, 100, 100, 100)));
      chk("rerun_ov_b", 64'(ov_b), 64'(0));

      rst = 1'b1; restart = 4'hF;
      tick(1);
      chk("rst_restart_c_b",    64'(c_b),    64'(0));
      chk("rst_restart_done_b", 64'(done_b), 64'(0));
      chk("rst_restart_c_w",    64'(c_w),    64'(0));
      chk("rst_restart_ov_w",   64'(ov_w),   64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
